// File: rtl/if_stage_pkg.sv
// Shared widths, reset constant and the IF-to-ID bundle layout for the fetch stage.
package if_stage_pkg;

  localparam int IfToPreifBusWidth = 32;
  localparam int PreifToIfBusWidth = 64;
  localparam int IfToIdBusWidth    = 130;
  localparam int InstSramDataWidth = 64;

  // Pre-IF adds 4 to the feedback PC, so the first fetch lands on 0x1c00_0000.
  localparam logic [31:0] ResetPcM4 = 32'h1bff_fffc;

  typedef struct packed {
    logic        adef;
    logic        slot2_v;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic [31:0] pc1;
    logic [31:0] inst1;
  } if_to_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// Holds the SRAM read word while ID back-pressures, so the RAM output may move on.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_i,
  input  logic                         clear_i,
  input  logic [InstSramDataWidth-1:0] data_i,
  output logic                         buf_valid_o,
  output logic [InstSramDataWidth-1:0] buf_data_o
);

  logic                         buf_valid_d, buf_valid_q;
  logic [InstSramDataWidth-1:0] buf_data_d, buf_data_q;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (clear_i) begin
      buf_valid_d = 1'b0;
    end else if (capture_i) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign buf_valid_o = buf_valid_q;
  assign buf_data_o  = buf_data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: accepts the pre-IF PC pair, reads the instruction SRAM and emits up to two instructions to ID.
// Optional feature: define IF_DUAL_FETCH_EN to issue the second slot and advance pre-IF by 8 bytes per fetch.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         preif_to_now_valid_i,
  output logic                         now_allowin_o,
  input  logic [PreifToIfBusWidth-1:0] pi_to_ibus,
  input  logic                         flush_i,
  output logic                         inst_sram_en_o,
  output logic [31:0]                  inst_sram_addr_o,
  input  logic [InstSramDataWidth-1:0] inst_sram_rdata_i,
  input  logic                         next_allowin_i,
  output logic                         now_to_next_valid_o,
  output logic [IfToPreifBusWidth-1:0] if_to_ibus,
  output logic [IfToIdBusWidth-1:0]    to_id_obus
);

  logic        if_valid_d, if_valid_q;
  logic [31:0] pc1_d, pc1_q;
  logic [31:0] pc2_d, pc2_q;
  logic [31:0] fb_pc_d, fb_pc_q;

  logic        allowin;
  logic        accept;
  logic        handshake;
  logic        buf_capture;
  logic        buf_clear;
  logic        buf_valid;
  logic [InstSramDataWidth-1:0] buf_data;
  logic [InstSramDataWidth-1:0] word;
  logic [31:0] in_pc1;
  logic [31:0] in_pc2;
  if_to_id_t   bundle;

  assign in_pc1 = pi_to_ibus[31:0];
  assign in_pc2 = pi_to_ibus[63:32];

  always_comb begin
    allowin     = !if_valid_q || next_allowin_i || flush_i;
    accept      = preif_to_now_valid_i && allowin;
    handshake   = if_valid_q && !flush_i && next_allowin_i;
    buf_capture = if_valid_q && !next_allowin_i && !buf_valid && !flush_i;
    buf_clear   = handshake || flush_i || accept;

    // A flush cycle still opens allowin, so the redirect target is taken here.
    if_valid_d = allowin ? preif_to_now_valid_i : if_valid_q;
    pc1_d      = accept ? in_pc1 : pc1_q;
    pc2_d      = accept ? in_pc2 : pc2_q;

    fb_pc_d = fb_pc_q;
    if (accept) begin
`ifdef IF_DUAL_FETCH_EN
      fb_pc_d = (in_pc1[2:0] == 3'b000) ? in_pc2 : in_pc1;
`else
      fb_pc_d = in_pc1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      pc1_q      <= '0;
      pc2_q      <= '0;
      fb_pc_q    <= ResetPcM4;
    end else begin
      if_valid_q <= if_valid_d;
      pc1_q      <= pc1_d;
      pc2_q      <= pc2_d;
      fb_pc_q    <= fb_pc_d;
    end
  end

  if_skid_buf u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .capture_i   (buf_capture),
    .clear_i     (buf_clear),
    .data_i      (inst_sram_rdata_i),
    .buf_valid_o (buf_valid),
    .buf_data_o  (buf_data)
  );

  always_comb begin
    word           = buf_valid ? buf_data : inst_sram_rdata_i;
    bundle         = '0;
    bundle.pc1     = pc1_q;
    bundle.pc2     = pc2_q;
    bundle.adef    = (pc1_q[1:0] != 2'b00);
    if (!bundle.adef) begin
      if (!pc1_q[2]) begin
        bundle.inst1 = word[31:0];
        bundle.inst2 = word[63:32];
      end else begin
        bundle.inst1 = word[63:32];
      end
    end
`ifdef IF_DUAL_FETCH_EN
    bundle.slot2_v = !pc1_q[2] && !bundle.adef;
`else
    bundle.slot2_v = 1'b0;
`endif
  end

  assign now_allowin_o       = allowin;
  assign now_to_next_valid_o = if_valid_q && !flush_i;
  assign inst_sram_en_o      = accept;
  assign inst_sram_addr_o    = {in_pc1[31:3], 3'b000};
  assign if_to_ibus          = fb_pc_q;
  assign to_id_obus          = bundle;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected bundles are queued on accept and compared while presented to ID.
module tb_if_stage;
  import if_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         preif_valid;
  logic         now_allowin_o;
  logic [63:0]  pi_bus;
  logic         flush;
  logic         inst_sram_en_o;
  logic [31:0]  inst_sram_addr_o;
  logic [63:0]  sram_rdata;
  logic         next_allowin;
  logic         now_to_next_valid_o;
  logic [31:0]  if_to_ibus;
  logic [129:0] to_id_obus;

  int n_cmp = 0;
  int n_err = 0;
  if_to_id_t   sb[$];
  logic [31:0] exp_fb;

  always #5 clk = ~clk;

  if_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .preif_to_now_valid_i(preif_valid),
    .now_allowin_o       (now_allowin_o),
    .pi_to_ibus          (pi_bus),
    .flush_i             (flush),
    .inst_sram_en_o      (inst_sram_en_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_rdata_i   (sram_rdata),
    .next_allowin_i      (next_allowin),
    .now_to_next_valid_o (now_to_next_valid_o),
    .if_to_ibus          (if_to_ibus),
    .to_id_obus          (to_id_obus)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] addr);
    return {addr ^ 32'h5a5a_0004, ~addr};
  endfunction

  // SRAM model: valid data one cycle after an enabled read, garbage otherwise.
  always @(posedge clk) begin
    if (inst_sram_en_o) sram_rdata <= mem_word(inst_sram_addr_o);
    else                sram_rdata <= {$urandom, $urandom};
  end

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic if_to_id_t model_bundle(input logic [31:0] pc);
    if_to_id_t   b;
    logic [63:0] w;
    w       = mem_word({pc[31:3], 3'b000});
    b       = '0;
    b.pc1   = pc;
    b.pc2   = pc + 32'd4;
    b.adef  = (pc[1:0] != 2'b00);
    if (!b.adef) begin
      b.inst1 = pc[2] ? w[63:32] : w[31:0];
      b.inst2 = w[63:32];
    end
`ifdef IF_DUAL_FETCH_EN
    b.slot2_v = !pc[2] && !b.adef;
`else
    b.slot2_v = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] model_fb(input logic [31:0] pc);
`ifdef IF_DUAL_FETCH_EN
    return (pc[2:0] == 3'b000) ? pc + 32'd4 : pc;
`else
    return pc;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; preif_valid = 1'b0; flush = 1'b0; next_allowin = 1'b1; pi_bus = '0;
    repeat (2) @(posedge clk);
    sb.delete();
    exp_fb = ResetPcM4;
  endtask

  task automatic step(input logic pv, input logic [31:0] pc, input logic na, input logic fl);
    if_to_id_t got, exp_b;
    logic      exp_allow, exp_valid;
    @(negedge clk);
    rst = 1'b0; preif_valid = pv; pi_bus = {pc + 32'd4, pc}; next_allowin = na; flush = fl;
    #1;
    exp_allow = (sb.size() == 0) || na || fl;
    exp_valid = (sb.size() != 0) && !fl;
    check("allowin",  {129'd0, now_allowin_o},       {129'd0, exp_allow});
    check("to_id_v",  {129'd0, now_to_next_valid_o}, {129'd0, exp_valid});
    check("sram_en",  {129'd0, inst_sram_en_o},      {129'd0, pv && exp_allow});
    check("fb_pc",    {98'd0, if_to_ibus},           {98'd0, exp_fb});
    if (exp_valid) begin
      got   = to_id_obus;
      exp_b = sb[0];
      check("adef",    {129'd0, got.adef},    {129'd0, exp_b.adef});
      check("slot2_v", {129'd0, got.slot2_v}, {129'd0, exp_b.slot2_v});
      check("pc1",     {98'd0, got.pc1},      {98'd0, exp_b.pc1});
      check("inst1",   {98'd0, got.inst1},    {98'd0, exp_b.inst1});
      if (exp_b.slot2_v) begin
        check("pc2",   {98'd0, got.pc2},      {98'd0, exp_b.pc2});
        check("inst2", {98'd0, got.inst2},    {98'd0, exp_b.inst2});
      end
      if (na) void'(sb.pop_front());
    end else if (fl && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    if (pv && exp_allow) begin
      check("sram_addr", {98'd0, inst_sram_addr_o}, {98'd0, pc[31:3], 3'b000});
      sb.push_back(model_bundle(pc));
      exp_fb = model_fb(pc);
    end
  endtask

  initial begin
    rst = 1'b1; preif_valid = 1'b0; flush = 1'b0; next_allowin = 1'b1; pi_bus = '0;
    sram_rdata = '0;
    exp_fb = ResetPcM4;

    // Reset state, then the first fetch at the reset target.
    do_reset();
    step(1'b1, 32'h1c00_0000, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    // Back-to-back stream with ID always ready.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h1c00_0008 + 32'(8 * i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Three-cycle stall while the SRAM output churns.
    step(1'b1, 32'h1c00_0040, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1c00_0048, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_0048, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    // Flush during a stall with the redirect target presented.
    step(1'b1, 32'h1c00_0080, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b0, 1'b0);
    step(1'b0, 32'h0,         1'b0, 1'b0);
    step(1'b1, 32'h1c00_0100, 1'b0, 1'b1);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    // Flush in the first stalled cycle: nothing buffered, new bundle then stalls.
    step(1'b1, 32'h1c00_0200, 1'b1, 1'b0);
    step(1'b1, 32'h1c00_0308, 1'b0, 1'b1);
    step(1'b0, 32'h0,         1'b0, 1'b0);
    step(1'b0, 32'h0,         1'b0, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    // Odd-word PC: single issue from the upper half.
    step(1'b1, 32'h1c00_0004, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    // Misaligned PC: adef bundle still reaches ID.
    step(1'b1, 32'h1c00_0002, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    // Reset in the middle of a stall.
    step(1'b1, 32'h1c00_0400, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b0, 1'b0);
    step(1'b0, 32'h0,         1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'h0,         1'b1, 1'b0);
    step(1'b1, 32'h1c00_0000, 1'b1, 1'b0);
    step(1'b0, 32'h0,         1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch pipeline stage of the dual-issue core: receives the PC pair from the pre-IF stage, accepts it through a valid/allowin handshake, and launches the synchronous instruction SRAM read. It holds the returned 64-bit fetch word across ID back-pressure, flags fetch-address errors, and emits up to two instructions to ID. It also returns the last-fetched PC to pre-IF as the base for the next sequential PC.

## Interface
- RESET_PC_M4, 32'h1bff_fffc, feedback PC after reset, so pre-IF's first sequential PC is 0x1c00_0000
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- preif_to_now_valid_i  in  1  pre-IF holds a valid PC pair
- now_allowin_o  out  1  IF accepts the PC pair this cycle
- pi_to_ibus  in  64  {pc2[31:0], pc1[31:0]}; pc2 = pc1+4
- flush_i  in  1  exception, ertn or taken branch: kill the current IF entry
- inst_sram_en_o  out  1  SRAM read enable
- inst_sram_addr_o  out  32  {pc1[31:3], 3'b000}
- inst_sram_rdata_i  in  64  SRAM data, valid one cycle after the enabled read
- next_allowin_i  in  1  ID can accept
- now_to_next_valid_o  out  1  IF presents a valid bundle to ID
- if_to_ibus  out  32  feedback PC to pre-IF
- to_id_obus  out  130  {adef, slot2_v, pc2, inst2, pc1, inst1}

## Operation
- State: `if_valid`, `pc1_r`, `pc2_r`, `buf_valid`, `buf_data[63:0]`, `fb_pc`.
- `ready_go` = 1.
- `now_allowin_o` = !if_valid | next_allowin_i | flush_i.
- `now_to_next_valid_o` = if_valid & !flush_i.
- Accept = preif_to_now_valid_i & now_allowin_o.
  - On accept, `inst_sram_en_o` = 1 and pc1/pc2 are latched.
  - The SRAM address is combinational from `pi_to_ibus`.
- Fetch word: `word` = buf_valid ? buf_data : inst_sram_rdata_i.
  - If pc1_r[2] = 0: inst1 = word[31:0], inst2 = word[63:32].
  - If pc1_r[2] = 1: inst1 = word[63:32].
- slot2_v = (pc1_r[2] = 0) & !adef.
- adef = (pc1_r[1:0] != 0).
  - When adef = 1: inst1 = inst2 = 0 and slot2_v = 0. The bundle still goes to ID so the exception can be raised there.
- Skid buffer:
  - If if_valid & !next_allowin_i & !buf_valid & !flush_i, capture inst_sram_rdata_i into buf_data and set buf_valid.
  - Clear buf_valid on a handshake to ID, on flush_i, or on a new accept.
- Flush:
  - The current entry and buffer are dropped next edge.
  - Pre-IF already presents the redirect target in the flush cycle, so a simultaneous accept is honoured: if_valid ← preif_to_now_valid_i.
- `fb_pc` updates on accept:
  - Pair is dual-fetchable (pc1[2] = 0, pc1[1:0] = 0): fb_pc ← pc2.
  - Otherwise: fb_pc ← pc1.
- `if_to_ibus` = fb_pc.

## Timing
- Reset:
  - if_valid = 0, buf_valid = 0, pc1_r = pc2_r = 0, fb_pc = RESET_PC_M4.
  - now_allowin_o = 1, now_to_next_valid_o = 0, inst_sram_en_o follows preif_to_now_valid_i.
- Latency: accept in cycle N; bundle valid to ID in N+1 with SRAM data.
- Throughput: one bundle per cycle while ID allows.
- Stall:
  - The first stalled cycle buffers the data. Later cycles serve buf_data, so the RAM output may change.
  - While stalled, no SRAM enable is issued and pre-IF input is ignored.
- Simultaneous stall and flush: flush wins and nothing is buffered.
- Reset asserted mid-stall clears all state in one edge.

## Configuration
- `IF_DUAL_FETCH_EN`
  - Defined: behaviour as above.
  - Undefined:
    - slot2_v is always 0, so inst2/pc2 are don't-care.
    - fb_pc always ← pc1, so pre-IF advances 4 bytes per fetch.
    - inst1 half-selection by pc1[2] is unchanged.

## Structure
- Shared package/header holds:
  - Bus widths IfToPreifBusWidth (32), PreifToIfBusWidth (64) and IfToIdBusWidth (130).
  - Reset-PC constant.
  - SRAM data width (64).
- Sub-module `if_skid_buf`: the 64-bit hold register with its capture/clear logic. Everything else stays in the top.

## Test plan
- Reset, then pre-IF valid with pc1 = 0x1c00_0000 → SRAM addr 0x1c00_0000, en = 1.
  - Next cycle: bundle valid, slot2_v = 1, if_to_ibus = 0x1c00_0004.
- Back-to-back stream with ID always ready → one valid bundle per cycle, instructions matching SRAM model contents, no bubbles.
- ID stalls 3 cycles while the SRAM model changes its output each cycle → inst1/inst2 stay at the first-cycle values and now_allowin_o = 0 throughout.
- flush_i during a stall with pre-IF presenting 0x1c00_0100 → old bundle never handed off, buffer cleared, next bundle pc1 = 0x1c00_0100.
- pc1 = 0x1c00_0004 → slot2_v = 0, inst1 = rdata[63:32], if_to_ibus = 0x1c00_0004.
- pc1 = 0x1c00_0002 → adef = 1, inst1 = 0, slot2_v = 0, bundle still valid to ID.
